// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC select encoding, default widths and branch-offset sign extension
package pc_pkg;
  localparam int PC_W_DEF = 32;
  localparam int OFF_W_DEF = 7;
  typedef enum logic [2:0] {PC_SEQ, PC_BR, PC_JMP, PC_CALL, PC_RET} pc_sel_e;
  function automatic logic [63:0] sext_off(input logic [63:0] f, input int w);
    return $signed(f << (64 - w)) >>> (64 - w);
  endfunction
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack that overwrites the oldest entry on overflow and flags misuse
module pc_ras #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty,
  output logic         err
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0] cnt;
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign top = mem[ptr - PW'(1)];
  always_ff @(posedge clk)
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (pop) begin
      if (empty) err <= 1'b1;
      else begin
        ptr <= ptr - PW'(1);
        cnt <= cnt - (PW+1)'(1);
      end
    end else if (push) begin
      mem[ptr] <= din;
      ptr <= ptr + PW'(1);
      if (full) err <= 1'b1;
      else cnt <= cnt + (PW+1)'(1);
    end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register with next-PC select, jump target table, stall/halt; return stack when PC_RAS_EN is defined
module pc_next_unit import pc_pkg::*; #(
  parameter int PC_W = PC_W_DEF,
  parameter int INSTR_W = 9,
  parameter int OFF_W = OFF_W_DEF,
  parameter int LUT_DEPTH = 16,
  parameter int RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         halt_req,
  input  logic [INSTR_W-1:0]           instr,
  input  logic                         branch,
  input  logic                         zero,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         lut_we,
  input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
  input  logic [PC_W-1:0]              lut_wdata,
  output logic [PC_W-1:0]              pc_out,
  output logic                         halted,
  output logic                         ras_err
);
  localparam int IDX_W = $clog2(LUT_DEPTH);
  logic [PC_W-1:0] lut [LUT_DEPTH];
  logic [PC_W-1:0] seq, off, nxt, ret_tgt;
  logic [IDX_W-1:0] idx;
  logic adv, ret_en, unused_ok;
  pc_sel_e sel;
  assign seq = pc_out + PC_W'(1);
  assign off = PC_W'(sext_off(64'(instr[OFF_W-1:0]), OFF_W));
  assign idx = instr[IDX_W-1:0];
  assign adv = ~stall & ~halted & ~halt_req;
  assign unused_ok = ^{instr, ret} ^ (RAS_DEPTH > 0);
`ifdef PC_RAS_EN
  logic [PC_W-1:0] ras_top;
  logic ras_empty, ras_full, unused_full;
  assign unused_full = ras_full;
  assign ret_en = ret;
  assign ret_tgt = ras_empty ? seq : ras_top;
  pc_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .push(adv & call & ~ret),
    .pop(adv & ret),
    .din(seq),
    .top(ras_top),
    .full(ras_full),
    .empty(ras_empty),
    .err(ras_err)
  );
`else
  assign ret_en = 1'b0;
  assign ret_tgt = seq;
  assign ras_err = 1'b0;
`endif
  always_comb begin
    sel = ret_en ? PC_RET : call ? PC_CALL : jump ? PC_JMP : (branch & zero) ? PC_BR : PC_SEQ;
    nxt = sel == PC_RET ? ret_tgt : (sel == PC_CALL || sel == PC_JMP) ? lut[idx] : sel == PC_BR ? seq + off : seq;
  end
  always_ff @(posedge clk)
    if (lut_we) lut[lut_waddr] <= lut_wdata;
  always_ff @(posedge clk)
    if (reset) begin
      pc_out <= RESET_PC;
      halted <= 1'b0;
    end else if (!stall && !halted) begin
      if (halt_req) halted <= 1'b1;
      else pc_out <= nxt;
    end
endmodule
